wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback-side driver for the 32x32 register file write port (WrEn_RF / WAddr_RF / WD_RF). It is the writer end of the interface whose reader is the decode stage.
- Merges two result sources: single-cycle ALU results and load-unit results.
- Load data is aligned and extended here. Loads are buffered in a small FIFO.
- Write-port access is arbitrated with a starvation guard, and at most one register-file write is issued per cycle.

Parameters:
LD_DEPTH, 2, load FIFO entries (power of 2, >=2)
STARVE_LIM, 4, consecutive ALU grants allowed while a load waits before the load is forced

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
ld_valid  in  1  load response present
ld_ready  out  1  load FIFO can accept
ld_rd  in  5  load destination register
ld_word  in  32  raw aligned memory word
ld_funct3  in  3  0=LB 1=LH 2=LW 4=LBU 5=LHU
ld_off  in  2  byte offset addr[1:0]
WrEn_RF  out  1  register-file write enable
WAddr_RF  out  5  register-file write address
WD_RF  out  32  register-file write data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO is emptied and the starvation counter is cleared.
  - WrEn_RF=0, WAddr_RF=0, WD_RF=0.
  - alu_ready=0 and ld_ready=0 while rst_n is low.
  - Any in-flight load is discarded.
- Load handshake:
  - A load transfers when ld_valid && ld_ready.
  - ld_ready = (count < LD_DEPTH). It depends only on registered count, not on a same-cycle pop.
- Load extraction happens at push time; the FIFO stores rd plus the final 32-bit value:
  - LB/LBU: byte ld_off, sign- or zero-extended.
  - LH/LHU: halfword ld_off[1] (ld_off[0] ignored), sign- or zero-extended.
  - LW and funct3 3/6/7: full word.
- Arbitration, combinational each cycle:
  - FIFO empty: grant ALU if alu_valid.
  - FIFO non-empty and alu_valid: grant ALU unless starve_cnt == STARVE_LIM, in which case grant the FIFO head.
  - FIFO non-empty and no alu_valid: grant the FIFO head.
  - alu_ready = grant_alu, so the ALU may be stalled only when a forced load is granted.
- Starvation counter (starve_cnt):
  - Increments on each ALU grant while the FIFO is non-empty.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIM.
- Write port: registered, 1-cycle latency from grant.
  - WrEn_RF = granted && (rd != 0).
  - WAddr_RF and WD_RF take the granted rd and data.
  - On a cycle with no grant, WrEn_RF=0 and WAddr_RF/WD_RF hold their previous values.
- rd==0: the result is consumed normally (alu_ready asserted or FIFO popped), but WrEn_RF stays 0.
- Same-cycle push into a non-full FIFO and pop are both honoured; count is unchanged.
- Pointers wrap modulo LD_DEPTH.

Optional Feature:
- WB_FWD_EN defined:
  - Adds outputs fwd_valid (1), fwd_rd (5), fwd_data (32).
  - These are combinational copies of the current-cycle grant (valid only if rd != 0), for the decode stage to bypass data that the register file has not yet stored.
  - They are also asserted during reset deassert cycles only if a grant exists.
- WB_FWD_EN undefined: ports absent, no extra logic.

Test Plan:
- Reset with the FIFO full (2 loads pushed), rst_n=0 for 1 cycle -> next cycle count=0, ld_ready=1, WrEn_RF=0, no queued load is ever written.
- ALU only: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle WrEn_RF=1, WAddr_RF=5, WD_RF=0xDEADBEEF. Repeat with rd=0 -> alu_ready=1, WrEn_RF=0.
- Load extraction, ld_word=0x8091A2F3 to rd=7:
  - LB off=3 -> WD_RF=0xFFFFFF80.
  - LBU off=0 -> 0x000000F3.
  - LH off=2 -> 0xFFFF8091.
  - LHU off=1 -> 0x0000A2F3.
  - LW -> 0x8091A2F3.
- Starvation with STARVE_LIM=4: one load queued, alu_valid held high -> 4 ALU writes, then cycle 5 alu_ready=0 and the load is written; cycle 6 the ALU resumes.
- FIFO full with alu_valid held and ld_valid held -> ld_ready=0 after 2 pushes. Releasing alu_valid -> writes drain in push order, with ld_ready reasserting one cycle after the first pop.
- WB_FWD_EN: ALU rd=9, data=0x12345678 -> fwd_valid=1, fwd_rd=9, fwd_data=0x12345678 in the grant cycle; WrEn_RF follows next cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-side driver for the register-file write port.
// Merges single-cycle ALU results with load responses buffered in a small
// FIFO, arbitrates with a starvation guard and issues at most one register
// write per cycle through a registered write port.
// Optional build macro: WB_FWD_EN adds combinational forwarding outputs
// (fwd_valid/fwd_rd/fwd_data) that mirror the current-cycle grant.

module wb_arbiter #(
  parameter int LD_DEPTH   = 2,  // power of 2, >= 2
  parameter int STARVE_LIM = 4   // >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_word,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  output logic        WrEn_RF,
  output logic [4:0]  WAddr_RF,
  output logic [31:0] WD_RF
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int AW = $clog2(LD_DEPTH);
  localparam int CW = $clog2(LD_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);
  localparam logic [SW-1:0] LIM_C   = SW'(STARVE_LIM);

  // FIFO storage: destination register plus the already-extended value
  logic [4:0]    mem_rd_q   [LD_DEPTH];
  logic [4:0]    mem_rd_d   [LD_DEPTH];
  logic [31:0]   mem_data_q [LD_DEPTH];
  logic [31:0]   mem_data_d [LD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  // Registered write port
  logic          wr_en_q, wr_en_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wd_q, wd_d;

  logic          fifo_empty;
  logic          force_ld;
  logic          grant_alu;
  logic          grant_ld;
  logic          push;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Align and extend the incoming load word so the FIFO holds final values
  always_comb begin
    ld_byte = 8'h00;
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h000000, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'h0000, ld_half};
      default: ld_ext = ld_word;
    endcase
  end

  // Arbitration: ALU wins unless a load has waited through STARVE_LIM ALU grants
  always_comb begin
    fifo_empty = (count_q == '0);
    force_ld   = (starve_q == LIM_C);
    grant_alu  = rst_n && alu_valid && (fifo_empty || !force_ld);
    grant_ld   = rst_n && !fifo_empty && (!alu_valid || force_ld);
    ld_ready   = rst_n && (count_q < DEPTH_C);
    alu_ready  = grant_alu;
    push       = ld_valid && ld_ready;
    if (grant_alu) begin
      win_rd   = alu_rd;
      win_data = alu_data;
    end else begin
      win_rd   = mem_rd_q[rd_ptr_q];
      win_data = mem_data_q[rd_ptr_q];
    end
  end

  // Next-state for FIFO, starvation counter and the write port
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    wr_en_d    = 1'b0;
    waddr_d    = waddr_q;
    wd_d       = wd_q;

    if (push) begin
      mem_rd_d[wr_ptr_q]   = ld_rd;
      mem_data_d[wr_ptr_q] = ld_ext;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (grant_ld) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, grant_ld})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (grant_ld || fifo_empty) begin
      starve_d = '0;
    end else if (grant_alu && (starve_q != LIM_C)) begin
      starve_d = starve_q + SW'(1);
    end

    if (grant_alu || grant_ld) begin
      wr_en_d = (win_rd != 5'd0);
      waddr_d = win_rd;
      wd_d    = win_data;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wr_en_q  <= 1'b0;
      waddr_q  <= 5'd0;
      wd_q     <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wr_en_q  <= wr_en_d;
      waddr_q  <= waddr_d;
      wd_q     <= wd_d;
    end
  end

  // FIFO payload needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  assign WrEn_RF  = wr_en_q;
  assign WAddr_RF = waddr_q;
  assign WD_RF    = wd_q;

`ifdef WB_FWD_EN
  assign fwd_valid = (grant_alu || grant_ld) && (win_rd != 5'd0);
  assign fwd_rd    = win_rd;
  assign fwd_data  = win_data;
`endif

endmodule
